// File: rtl/qdec_tu_egk_fsm.sv
// CABAC sub-FSM: context-coded truncated-unary prefix, bypass EGk suffix, optional bypass sign.
// Define QDEC_TUEGK_BINCNT_EN to add the bin_cnt output (bins consumed per element, saturating).
module qdec_tu_egk_fsm #(
  parameter int PREFIX_MAX    = 5,
  parameter int CTX_NUM       = 2,
  parameter int EGK           = 0,
  parameter int MAX_EG_PREFIX = 10,
  parameter int CTX_AW        = 10,
  parameter int VAL_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign_en,
  input  logic [CTX_AW-1:0] ctx_base,
  output logic              bin_req,
  output logic [CTX_AW-1:0] bin_ctx_addr,
  output logic              bin_ep_mode,
  input  logic              bin_rdy,
  input  logic              bin,
  input  logic              bin_vld,
  output logic [VAL_W-1:0]  value,
  output logic              sign,
  output logic              done,
`ifdef QDEC_TUEGK_BINCNT_EN
  output logic [7:0]        bin_cnt,
`endif
  output logic              err
);
  localparam int PW = $clog2(PREFIX_MAX + 1);
  localparam int UW = $clog2(MAX_EG_PREFIX + 1);
  localparam int KW = $clog2(EGK + MAX_EG_PREFIX + 1);

  if (VAL_W < $clog2(PREFIX_MAX + (2 ** (EGK + MAX_EG_PREFIX + 1)))) begin : g_bad_val_w
    $error("VAL_W too narrow for PREFIX_MAX/EGK/MAX_EG_PREFIX");
  end

  typedef enum logic [2:0] {IDLE, PREFIX, SUF_UNARY, SUF_BITS, SIGN, DONE} state_t;

  state_t            state, state_n;
  logic              outst, outst_n;
  logic [PW-1:0]     p, p_n, p_inc;
  logic [UW-1:0]     u, u_n, u_inc;
  logic [KW-1:0]     kk, kk_n, rem, rem_n;
  logic [VAL_W-1:0]  acc, acc_n, acc_b, value_n;
  logic              sign_n, err_n, done_n;
  logic              sign_en_q, sign_en_n;
  logic [CTX_AW-1:0] ctx_base_q, ctx_base_n;
  logic              need, take;
  int                p_ctx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      outst      <= 1'b0;
      p          <= '0;
      u          <= '0;
      kk         <= '0;
      rem        <= '0;
      acc        <= '0;
      value      <= '0;
      sign       <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      sign_en_q  <= 1'b0;
      ctx_base_q <= '0;
    end else begin
      state      <= state_n;
      outst      <= outst_n;
      p          <= p_n;
      u          <= u_n;
      kk         <= kk_n;
      rem        <= rem_n;
      acc        <= acc_n;
      value      <= value_n;
      sign       <= sign_n;
      err        <= err_n;
      done       <= done_n;
      sign_en_q  <= sign_en_n;
      ctx_base_q <= ctx_base_n;
    end
  end

  always_comb begin
    state_n    = state;
    outst_n    = outst;
    p_n        = p;
    u_n        = u;
    kk_n       = kk;
    rem_n      = rem;
    acc_n      = acc;
    value_n    = value;
    sign_n     = sign;
    err_n      = err;
    done_n     = 1'b0;
    sign_en_n  = sign_en_q;
    ctx_base_n = ctx_base_q;
    p_inc      = p + PW'(1);
    u_inc      = u + UW'(1);
    acc_b      = acc + (VAL_W'(bin) << (rem - KW'(1)));
    p_ctx      = (int'(p) < CTX_NUM - 1) ? int'(p) : CTX_NUM - 1;

    need         = (state == PREFIX) || (state == SUF_UNARY) || (state == SUF_BITS) || (state == SIGN);
    bin_req      = need && !outst && bin_rdy;
    bin_ep_mode  = bin_req && (state != PREFIX);
    bin_ctx_addr = (bin_req && state == PREFIX) ? ctx_base_q + CTX_AW'(p_ctx) : '0;
    // a bin only counts when it answers our own outstanding request
    take         = bin_vld && outst;
    if (bin_req)   outst_n = 1'b1;
    else if (take) outst_n = 1'b0;

    case (state)
      IDLE: if (start) begin
        value_n    = '0;
        sign_n     = 1'b0;
        err_n      = 1'b0;
        p_n        = '0;
        u_n        = '0;
        kk_n       = '0;
        rem_n      = '0;
        acc_n      = '0;
        sign_en_n  = sign_en;
        ctx_base_n = ctx_base;
        state_n    = PREFIX;
      end
      PREFIX: if (take) begin
        if (bin) begin
          p_n = p_inc;
          if (p_inc == PW'(PREFIX_MAX)) begin
            acc_n   = '0;
            kk_n    = KW'(EGK);
            u_n     = '0;
            state_n = SUF_UNARY;
          end
        end else begin
          value_n = VAL_W'(p);
          state_n = (sign_en_q && p != '0) ? SIGN : DONE;
        end
      end
      SUF_UNARY: if (take) begin
        if (bin) begin
          acc_n = acc + (VAL_W'(1) << kk);
          kk_n  = kk + KW'(1);
          u_n   = u_inc;
          if (u_inc == UW'(MAX_EG_PREFIX)) begin
            err_n   = 1'b1;
            value_n = '0;
            sign_n  = 1'b0;
            state_n = DONE;
          end
        end else if (kk != '0) begin
          rem_n   = kk;
          state_n = SUF_BITS;
        end else begin
          value_n = VAL_W'(PREFIX_MAX) + acc;
          state_n = sign_en_q ? SIGN : DONE;
        end
      end
      SUF_BITS: if (take) begin
        acc_n = acc_b;
        rem_n = rem - KW'(1);
        if (rem == KW'(1)) begin
          value_n = VAL_W'(PREFIX_MAX) + acc_b;
          state_n = sign_en_q ? SIGN : DONE;
        end
      end
      SIGN: if (take) begin
        sign_n  = bin;
        state_n = DONE;
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef QDEC_TUEGK_BINCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        bin_cnt <= '0;
    else if (state == IDLE && start) bin_cnt <= '0;
    else if (take && bin_cnt != 8'hff) bin_cnt <= bin_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_qdec_tu_egk_fsm.sv
// Randomized scoreboard bench: elements are binarised by a reference encoder, a responder
// plays the arithmetic decoder, and a monitor checks each done against the expected result.
module tb_qdec_tu_egk_fsm;
  localparam int PM = 5;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sign_en = 1'b0;
  logic [9:0] ctx_base = '0;
  logic       bin_req, bin_ep_mode, bin_rdy = 1'b1, bin = 1'b0, bin_vld = 1'b0;
  logic [9:0] bin_ctx_addr;
  logic [15:0] value;
  logic       sign, done, err;
`ifdef QDEC_TUEGK_BINCNT_EN
  logic [7:0] bin_cnt;
`endif

  qdec_tu_egk_fsm dut (
    .clk(clk), .rst(rst), .start(start), .sign_en(sign_en), .ctx_base(ctx_base),
    .bin_req(bin_req), .bin_ctx_addr(bin_ctx_addr), .bin_ep_mode(bin_ep_mode),
    .bin_rdy(bin_rdy), .bin(bin), .bin_vld(bin_vld),
    .value(value), .sign(sign), .done(done),
`ifdef QDEC_TUEGK_BINCNT_EN
    .bin_cnt(bin_cnt),
`endif
    .err(err));

  always #5 clk = ~clk;

  typedef struct { logic [9:0] addr; bit ep; bit b; } req_t;
  typedef struct { int v; bit s; bit e; int n; } exp_t;
  req_t req_q[$];
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0, last_vld = 0, done_cnt = 0;
  bit resp_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int ex);
    n_chk++;
    if (act != ex) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, ex, cyc);
    end
  endfunction

  function automatic void push_req(logic [9:0] a, bit ep, bit b);
    req_t r;
    r.addr = a; r.ep = ep; r.b = b;
    req_q.push_back(r);
  endfunction

  // reference encoder: value -> TU prefix + EGk suffix + sign bins
  task automatic build(input int v, input bit s, input bit se, input bit ovf, input logic [9:0] cb);
    exp_t e;
    int r, k, n0;
    n0 = req_q.size();
    if (ovf) begin
      for (int i = 0; i < PM; i++) push_req(cb + 10'((i < 1) ? i : 1), 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) push_req('0, 1'b1, 1'b1);
    end else if (v < PM) begin
      for (int i = 0; i < v; i++) push_req(cb + 10'((i < 1) ? i : 1), 1'b0, 1'b1);
      push_req(cb + 10'((v < 1) ? v : 1), 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < PM; i++) push_req(cb + 10'((i < 1) ? i : 1), 1'b0, 1'b1);
      r = v - PM; k = 0;
      while (r >= (1 << k)) begin
        push_req('0, 1'b1, 1'b1);
        r -= (1 << k); k++;
      end
      push_req('0, 1'b1, 1'b0);
      for (int b = k - 1; b >= 0; b--) push_req('0, 1'b1, bit'((r >> b) & 1));
    end
    if (!ovf && se && v > 0) push_req('0, 1'b1, s);
    e.v = ovf ? 0 : v;
    e.s = (!ovf && se && v > 0) ? s : 1'b0;
    e.e = ovf;
    e.n = req_q.size() - n0;
    exp_q.push_back(e);
  endtask

  // arithmetic-decoder model
  initial begin
    req_t r;
    @(negedge clk);
    forever begin
      #1;
      if (resp_en && bin_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
          @(negedge clk);
        end else begin
          r = req_q.pop_front();
          chk("req_ep", int'(bin_ep_mode), int'(r.ep));
          if (!r.ep) chk("req_addr", int'(bin_ctx_addr), int'(r.addr));
          repeat ($urandom_range(1, 3)) @(negedge clk);
          bin = r.b; bin_vld = 1'b1; last_vld = cyc;
          @(negedge clk);
          bin_vld = 1'b0;
        end
      end else @(negedge clk);
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("value", int'(value), e.v);
          chk("sign", int'(sign), int'(e.s));
          chk("err", int'(err), int'(e.e));
          chk("done_latency", cyc - last_vld, 2);
`ifdef QDEC_TUEGK_BINCNT_EN
          chk("bin_cnt", int'(bin_cnt), (e.n > 255) ? 255 : e.n);
`endif
        end
      end
    end
  end

  task automatic run_elem(input int v, input bit s, input bit se, input bit ovf,
                          input int stall, input bit spur);
    int tgt, n, t;
    logic [9:0] cb;
    cb = ($urandom_range(0, 1) != 0) ? 10'd100 : 10'($urandom_range(0, 1000));
    build(v, s, se, ovf, cb);
    tgt = done_cnt + 1;
    n = (stall > 2) ? stall : 2;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      start    = (i == 0) || (spur && i == 1);
      ctx_base = (i == 0) ? cb : (cb ^ 10'h155);
      sign_en  = (i == 0) ? se : ~se;
      bin_rdy  = (i >= stall);
      #1;
      if (i < stall) chk("stall_no_req", int'(bin_req), 0);
      @(negedge clk);
    end
    start = 1'b0; bin_rdy = 1'b1;
    t = 0;
    while (done_cnt < tgt && t < 3000) begin @(negedge clk); t++; end
    if (done_cnt < tgt) begin
      chk("done_timeout", 0, 1);
      rst = 1'b1; req_q.delete(); exp_q.delete();
      @(negedge clk); rst = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (bin_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("manual_req_timeout", 0, 1);
  endtask

  task automatic answer(input bit b);
    bit ok;
    wait_req(ok);
    @(negedge clk);
    bin = b; bin_vld = 1'b1; last_vld = cyc;
    @(negedge clk);
    bin_vld = 1'b0;
  endtask

  initial begin
    bit ok;
    int v;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bin_req", int'(bin_req), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_sign", int'(sign), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;

    run_elem(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_elem(2, 1'b1, 1'b1, 1'b0, 7, 1'b0);
    run_elem(5, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_elem(10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_elem(0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_elem(3, 1'b1, 1'b1, 1'b0, 0, 1'b1);

    // reset while a suffix bit is being requested
    resp_en = 1'b0;
    @(negedge clk);
    start = 1'b1; sign_en = 1'b0; ctx_base = 10'd100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < PM + 1; i++) answer(1'b1);
    answer(1'b0);
    wait_req(ok);
    rst = 1'b1;
    #1;
    chk("midrst_bin_req", int'(bin_req), 0);
    chk("midrst_value", int'(value), 0);
    chk("midrst_sign", int'(sign), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); bin = 1'b1; bin_vld = 1'b1;
    @(negedge clk); bin_vld = 1'b0;
    repeat (4) begin
      #1;
      chk("stray_vld_req", int'(bin_req), 0);
      chk("stray_vld_done", int'(done), 0);
      @(negedge clk);
    end
    resp_en = 1'b1;
    run_elem(7, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: v = $urandom_range(0, 7);
        5, 6, 7:       v = $urandom_range(0, 40);
        default:       v = $urandom_range(0, PM + 1022);
      endcase
      run_elem(v, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("req_q_empty", req_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/qdec_tu_egk_fsm.md
Name: qdec_tu_egk_fsm

Overview:
- Parametrised CABAC syntax-element sub-FSM. Decodes one element binarised as a context-coded truncated-unary prefix, then a bypass EGk suffix, then an optional bypass sign bin.
- Generalises the delta-QP sub-FSM: prefix length, context count, EG order and suffix cap are parameters, so one block serves cu_qp_delta_abs, cu_chroma_qp_offset_idx, coeff-remainder-style elements, etc.
- Sits between the CU/TU FSMs and the arithmetic decoder. Issues one bin request at a time and accumulates the value.

Parameters:
- PREFIX_MAX, 5: cMax of the TU prefix, in bins, >=1. Reaching it enables the suffix.
- CTX_NUM, 2: context indices used by the prefix. Bin i uses ctx_base+min(i,CTX_NUM-1).
- EGK, 0: Exp-Golomb order k of the suffix.
- MAX_EG_PREFIX, 10: maximum suffix unary ones before the error condition.
- CTX_AW, 10: context address width.
- VAL_W, 16: value width. Elaboration check: VAL_W >= clog2(PREFIX_MAX+2^(EGK+MAX_EG_PREFIX+1)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin decoding one element
- sign_en  in  1  decode a sign bin when value>0; sampled on start
- ctx_base  in  CTX_AW  first context index of the element; sampled on start
- bin_req  out  1  one-cycle bin request to the arithmetic decoder
- bin_ctx_addr  out  CTX_AW  context address; valid with bin_req
- bin_ep_mode  out  1  1 = bypass bin; valid with bin_req
- bin_rdy  in  1  arithmetic decoder can accept a request
- bin  in  1  decoded bin value
- bin_vld  in  1  bin valid; answers the outstanding request
- value  out  VAL_W  decoded absolute value; held until the next start
- sign  out  1  decoded sign, 1 = negative; held until the next start
- done  out  1  one-cycle completion pulse
- err  out  1  suffix overflow flag; valid with done and held

Behaviour:
- Reset values: all outputs 0, state IDLE, outstanding flag 0. Reset mid-operation aborts immediately and drops any outstanding request.
- States: IDLE, PREFIX, SUF_UNARY, SUF_BITS, SIGN, DONE.
- Request rule:
  - bin_req rises when the state needs a bin, no request is outstanding, and bin_rdy=1.
  - The request sets outstanding; bin_vld clears it.
  - The earliest next bin_req is the cycle after bin_vld.
  - bin_vld while nothing is outstanding is ignored, including in IDLE.
- IDLE:
  - On start: clear value, sign, err and counters; latch sign_en and ctx_base; go to PREFIX.
  - start in any other state is ignored.
- PREFIX:
  - Request with ep=0 and addr=ctx_base+min(p,CTX_NUM-1). On each bin 1, p++.
  - bin 0 with p<PREFIX_MAX: value=p; go to SIGN if sign_en and p>0, else DONE.
  - p reaching PREFIX_MAX: go to SUF_UNARY with acc=0, kk=EGK, u=0.
- SUF_UNARY:
  - ep=1. bin 1: acc+=1<<kk, kk++, u++.
  - bin 0: if kk>0 go to SUF_BITS with kk bits remaining, else value=PREFIX_MAX+acc and go to SIGN/DONE.
  - u reaching MAX_EG_PREFIX with the last bin 1: err=1, value=0, sign=0; go to DONE without a sign bin.
- SUF_BITS:
  - ep=1. Bits arrive MSB first; acc+=bin<<(remaining-1).
  - After the last bit: value=PREFIX_MAX+acc; go to SIGN if sign_en, else DONE. value>0 holds here since PREFIX_MAX>=1.
- SIGN: ep=1 bypass bin; sign=bin; go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. A start arriving in this cycle is ignored.
- Latency: done is asserted 2 cycles after the final bin_vld (DONE state, registered).
- Arithmetic: acc is VAL_W wide, unsigned, with no wrap given the elaboration check.
- bin_rdy low stalls requests indefinitely. State and counters hold during the stall.

Optional Feature:
- Macro QDEC_TUEGK_BINCNT_EN.
- When defined: adds output bin_cnt [7:0], the total bins consumed by the element, including the sign bin. It saturates at 255, is valid with done, is held until the next start, and resets to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
All scenarios use the defaults PREFIX_MAX=5, EGK=0, CTX_NUM=2, ctx_base=100.
- Prefix zero: start with sign_en=1, bins 0 -> one request at addr 100 with ep=0; value=0, sign=0, no sign request, done 2 cycles after bin_vld.
- Short value with sign: bins 1,1,0 then sign bin 1 -> addrs 100,101,101 with ep 0,0,0, then ep=1; value=2, sign=1 (bin_cnt=4 when enabled).
- Prefix saturated, empty suffix: bins 1x5, then 0, then sign 0 -> value=5, sign=0. The 6th request has ep=1.
- EG0 suffix: bins 1x5, 1,1,0, then bits 1,0 -> acc=1+2+2; value=10, err=0, sign skipped when sign_en=0.
- Overflow: bins 1x5, then 1x10 -> err=1, value=0, done with no sign request. The next start clears err.
- Robustness:
  - bin_rdy held low for 7 cycles -> no bin_req during the stall.
  - start pulsed mid-PREFIX -> ignored.
  - rst asserted during SUF_BITS -> all outputs 0 immediately; a stray bin_vld afterwards is ignored.
  - A fresh start then decodes correctly.
